// File: rtl/spectrum_bar_renderer_pkg.sv
// spectrum_pkg: shared colours, FSM states and level saturation for spectrum_bar_renderer.
// No ports. Used by spectrum_bar_renderer and spectrum_bin_state.
package spectrum_pkg;

    localparam logic [7:0] BLK = 8'h00;
    localparam logic [7:0] WHT = 8'hff;
    localparam logic [7:0] RED = 8'he0;
    localparam logic [7:0] BLU = 8'h03;

    typedef enum logic [1:0] {IDLE, CAPTURE, UPDATE} state_t;

    // Clamp at full width so an oversized bin saturates instead of wrapping.
    function automatic logic [63:0] sat_level(input logic [63:0] v, input logic [63:0] rows);
        return (v > rows) ? rows : v;
    endfunction

endpackage

// File: rtl/spectrum_bar_renderer_if.sv
// spectrum_bar_renderer_if: groups the VGA counters, bin vector and pixel outputs.
// master: drives hc, vc, sound_signal, switches, current_sound; reads pixel outputs.
// slave : the renderer; reads the inputs, drives pixel_address, red/green/blue, frame_tick.
interface spectrum_bar_renderer_if #(
    parameter int NUM_BINS = 16,
    parameter int BIN_W    = 16
);
    logic [9:0]              hc;
    logic [9:0]              vc;
    logic [NUM_BINS*BIN_W-1:0] sound_signal;
    logic [3:0]              switches;
    logic [15:0]             current_sound;
    logic [9:0]              pixel_address;
    logic [2:0]              red;
    logic [2:0]              green;
    logic [1:0]              blue;
    logic                    frame_tick;

    modport master (
        output hc, vc, sound_signal, switches, current_sound,
        input  pixel_address, red, green, blue, frame_tick
    );

    modport slave (
        input  hc, vc, sound_signal, switches, current_sound,
        output pixel_address, red, green, blue, frame_tick
    );
endinterface

// File: rtl/spectrum_bar_renderer_bin_state.sv
// spectrum_bin_state: per-bin displayed level (fall-off smoothing) and optional peak-hold marker.
// Ports: vga_clk, reset (sync, active-high); en_i selects this bin during the update pass;
// lvl_i new saturated level; decay_i one-level fall-off this frame; disp_o displayed level;
// peak_o peak marker level (only with SPECTRUM_PEAK_HOLD_EN defined).
module spectrum_bin_state #(
    parameter int LVL_W       = 6,
    parameter int HOLD_FRAMES = 30
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             decay_i,
    input  logic [LVL_W-1:0] lvl_i,
`ifdef SPECTRUM_PEAK_HOLD_EN
    output logic [LVL_W-1:0] peak_o,
`endif
    output logic [LVL_W-1:0] disp_o
);
    logic [LVL_W-1:0] disp_q, disp_d;

    // lvl_i < disp_q implies disp_q > 0, so the decrement cannot underflow.
    always_comb disp_d = !en_i ? disp_q : (lvl_i >= disp_q) ? lvl_i : disp_q - LVL_W'(decay_i);

    always_ff @(posedge vga_clk) begin
        if (reset) disp_q <= '0;
        else       disp_q <= disp_d;
    end

    assign disp_o = disp_q;

`ifdef SPECTRUM_PEAK_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    logic [LVL_W-1:0]  peak_q, peak_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rise;

    assign rise = lvl_i >= peak_q;

    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (en_i) begin
            peak_d = rise ? lvl_i : (hold_q != '0) ? peak_q : peak_q - LVL_W'(decay_i);
            hold_d = rise ? HOLD_W'(HOLD_FRAMES) : (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    assign peak_o = peak_q;
`endif

endmodule

// File: rtl/spectrum_bar_renderer.sv
// spectrum_bar_renderer: frame-synchronous spectrum bar renderer between FFT output and VGA controller.
// Ports: vga_clk pixel clock; reset sync active-high; bus (slave) carries hc/vc counters,
// sound_signal bin vector, switches (per-bin right shift), current_sound loudness, and returns
// registered pixel_address, red/green/blue (3/3/2) and the frame_tick end-of-update pulse.
// Optional feature: define SPECTRUM_PEAK_HOLD_EN for per-bin peak-hold markers.
module spectrum_bar_renderer
    import spectrum_pkg::*;
#(
    parameter int          NUM_BINS     = 16,
    parameter int          BIN_W        = 16,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          ROWS         = 32,
    parameter int          DECAY_FRAMES = 4,
    parameter int          HOLD_FRAMES  = 30,
    parameter logic [15:0] THRESHOLD    = 16'h0900
) (
    input logic                    vga_clk,
    input logic                    reset,
    spectrum_bar_renderer_if.slave bus
);
    localparam int LVL_W  = $clog2(ROWS + 1);
    localparam int IDX_W  = $clog2(NUM_BINS);
    localparam int DIV_W  = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam int COL_PX = H_ACTIVE / NUM_BINS;
    localparam int ROW_PX = V_ACTIVE / ROWS;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic [NUM_BINS*BIN_W-1:0] sound_q;
    logic [3:0]                sw_q;
    logic [15:0]               cur_q;
    logic                      trigger, last, cap, upd, decay;
    logic [BIN_W-1:0]          shifted;
    logic [LVL_W-1:0]          lvl;
    logic [LVL_W-1:0]          disp [NUM_BINS];

    // FSM: state register
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM: next state; idx wraps to 0 after the last bin since NUM_BINS is a power of two
    assign trigger = bus.hc == 10'(H_ACTIVE) && bus.vc == 10'(V_ACTIVE);
    assign last    = idx_q == IDX_W'(NUM_BINS - 1);

    always_comb begin
        state_d = (state_q == IDLE)    ? (trigger ? CAPTURE : IDLE) :
                  (state_q == CAPTURE) ? UPDATE :
                  (last ? IDLE : UPDATE);
        idx_d   = (state_q == UPDATE) ? idx_q + 1'b1 : '0;
    end

    // FSM: outputs
    always_comb begin
        cap            = state_q == CAPTURE;
        upd            = state_q == UPDATE;
        bus.frame_tick = upd && last;
    end

    // Shadow copies keep the whole pass consistent even if the inputs move mid-pass.
    assign div_d = (div_q == DIV_W'(DECAY_FRAMES - 1)) ? '0 : div_q + 1'b1;
    assign decay = div_q == DIV_W'(DECAY_FRAMES - 1);

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            div_q   <= '0;
            sound_q <= '0;
            sw_q    <= '0;
            cur_q   <= '0;
        end else if (cap) begin
            div_q   <= div_d;
            sound_q <= bus.sound_signal;
            sw_q    <= bus.switches;
            cur_q   <= bus.current_sound;
        end
    end

    assign shifted = sound_q[idx_q*BIN_W +: BIN_W] >> sw_q;
    assign lvl     = LVL_W'(sat_level(64'(shifted), 64'(ROWS)));

`ifdef SPECTRUM_PEAK_HOLD_EN
    logic [LVL_W-1:0] peak [NUM_BINS];
`endif

    for (genvar i = 0; i < NUM_BINS; i++) begin : g_bin
        spectrum_bin_state #(
            .LVL_W      (LVL_W),
            .HOLD_FRAMES(HOLD_FRAMES)
        ) u_bin (
            .vga_clk(vga_clk),
            .reset  (reset),
            .en_i   (upd && idx_q == IDX_W'(i)),
            .decay_i(decay),
            .lvl_i  (lvl),
`ifdef SPECTRUM_PEAK_HOLD_EN
            .peak_o (peak[i]),
`endif
            .disp_o (disp[i])
        );
    end

    // Pixel path: one register stage from hc/vc to address and colour.
    logic             act, lit;
    logic [IDX_W-1:0] col;
    logic [LVL_W-1:0] row;
    logic [7:0]       bar_c, px_d, px_q;
    logic [9:0]       addr_d, addr_q;

    assign act   = bus.hc < 10'(H_ACTIVE) && bus.vc < 10'(V_ACTIVE);
    assign col   = IDX_W'(bus.hc / 10'(COL_PX));
    assign row   = LVL_W'(bus.vc / 10'(ROW_PX));
    assign lit   = LVL_W'(ROWS - 1) - row < disp[col];
    assign bar_c = (cur_q > THRESHOLD) ? RED : WHT;

`ifdef SPECTRUM_PEAK_HOLD_EN
    logic mark;
    assign mark = peak[col] != '0 && row == LVL_W'(ROWS) - peak[col];
    assign px_d = !act ? BLK : mark ? BLU : lit ? bar_c : BLK;
`else
    assign px_d = !act ? BLK : lit ? bar_c : BLK;
`endif
    assign addr_d = act ? 10'(row * NUM_BINS + col) : '0;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            px_q   <= BLK;
            addr_q <= '0;
        end else begin
            px_q   <= px_d;
            addr_q <= addr_d;
        end
    end

    assign bus.red           = px_q[7:5];
    assign bus.green         = px_q[4:2];
    assign bus.blue          = px_q[1:0];
    assign bus.pixel_address = addr_q;

endmodule

// File: tb/tb_spectrum_bar_renderer.sv
// tb_spectrum_bar_renderer: directed self-checking bench for spectrum_bar_renderer (default parameters).
module tb_spectrum_bar_renderer;
    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   failures = 0;

    spectrum_bar_renderer_if #(.NUM_BINS(16), .BIN_W(16)) bus ();

    spectrum_bar_renderer dut (
        .vga_clk(vga_clk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 vga_clk = ~vga_clk;

    // Expected colour of a col-0-style pixel at bar row for displayed level d and peak p.
    function automatic logic [7:0] exp_px(input int row, input int d, input int p, input bit hot);
`ifdef SPECTRUM_PEAK_HOLD_EN
        if (p > 0 && row == 32 - p) return 8'h03;
`endif
        return (31 - row < d) ? (hot ? 8'he0 : 8'hff) : 8'h00;
    endfunction

    task automatic do_reset();
        @(negedge vga_clk);
        reset = 1'b1;
        bus.hc = 10'd700;
        bus.vc = 10'd500;
        bus.sound_signal = '0;
        bus.switches = 4'd0;
        bus.current_sound = 16'd0;
        repeat (2) @(negedge vga_clk);
        reset = 1'b0;
    endtask

    task automatic set_bin(input int i, input logic [15:0] v);
        bus.sound_signal[i*16 +: 16] = v;
    endtask

    // Trigger one pass and watch 24 cycles; pos is the negedge index of the first frame_tick.
    task automatic run_pass(output int ticks, output int pos);
        @(negedge vga_clk);
        bus.hc = 10'd640;
        bus.vc = 10'd480;
        ticks = 0;
        pos = 0;
        for (int n = 1; n <= 24; n++) begin
            @(negedge vga_clk);
            if (n == 1) begin
                bus.hc = 10'd700;
                bus.vc = 10'd500;
            end
            if (bus.frame_tick) begin
                ticks++;
                if (pos == 0) pos = n;
            end
        end
    endtask

    task automatic probe(input int h, input int v, output logic [7:0] px, output logic [9:0] ad);
        @(negedge vga_clk);
        bus.hc = 10'(h);
        bus.vc = 10'(v);
        @(negedge vga_clk);
        px = {bus.red, bus.green, bus.blue};
        ad = bus.pixel_address;
    endtask

    task automatic test_reset();
        @(negedge vga_clk);
        reset = 1'b1;
        bus.hc = 10'd10;
        bus.vc = 10'd479;
        bus.sound_signal = '0;
        bus.switches = 4'd0;
        bus.current_sound = 16'd0;
        repeat (3) @(negedge vga_clk);
        checks++;
        if ({bus.red, bus.green, bus.blue, bus.pixel_address, bus.frame_tick} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs got rgb=%h addr=%0d tick=%b want all 0",
                     {bus.red, bus.green, bus.blue}, bus.pixel_address, bus.frame_tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int ticks, pos;
        logic [7:0] px;
        logic [9:0] ad;
        int vs[4] = '{479, 0, 247, 232};
        int rs[4] = '{31, 0, 16, 15};
        do_reset();
        set_bin(0, 16'h0100);
        bus.switches = 4'd4;
        run_pass(ticks, pos);
        checks++;
        if (ticks !== 1 || pos !== 17) begin
            failures++;
            $display("FAIL basic_tick got ticks=%0d pos=%0d want ticks=1 pos=17", ticks, pos);
        end
        for (int i = 0; i < 4; i++) begin
            probe(10, vs[i], px, ad);
            checks++;
            if ({px, ad} !== {exp_px(rs[i], 16, 16, 0), 10'(rs[i] * 16)}) begin
                failures++;
                $display("FAIL basic_px vc=%0d got px=%h addr=%0d want px=%h addr=%0d",
                         vs[i], px, ad, exp_px(rs[i], 16, 16, 0), rs[i] * 16);
            end
        end
    endtask

    task automatic test_saturation();
        int ticks, pos;
        logic [7:0] px;
        logic [9:0] ad;
        int hs[8] = '{130, 130, 50, 50, 90, 640, 639, 130};
        int vs[8] = '{7, 472, 7, 22, 7, 0, 479, 247};
        int rs[8] = '{0, 31, 0, 1, 0, 0, 31, 16};
        int ds[8] = '{32, 32, 31, 31, 32, 0, 0, 32};
        logic [9:0] as[8] = '{10'd3, 10'd499, 10'd1, 10'd17, 10'd2, 10'd0, 10'd511, 10'd259};
        do_reset();
        set_bin(3, 16'hffff);
        set_bin(1, 16'd31);
        set_bin(2, 16'd32);
        run_pass(ticks, pos);
        for (int i = 0; i < 8; i++) begin
            probe(hs[i], vs[i], px, ad);
            checks++;
            if ({px, ad} !== {exp_px(rs[i], ds[i], ds[i], 0) & {8{i != 5}}, as[i]}) begin
                failures++;
                $display("FAIL sat_px hc=%0d vc=%0d got px=%h addr=%0d want px=%h addr=%0d", hs[i], vs[i],
                         px, ad, exp_px(rs[i], ds[i], ds[i], 0) & {8{i != 5}}, as[i]);
            end
        end
        // Largest shift: 0xffff >> 15 = 1, only the bottom row lit.
        do_reset();
        set_bin(3, 16'hffff);
        bus.switches = 4'd15;
        run_pass(ticks, pos);
        for (int r = 30; r <= 31; r++) begin
            probe(130, r * 15 + 7, px, ad);
            checks++;
            if (px !== exp_px(r, 1, 1, 0)) begin
                failures++;
                $display("FAIL sat_shift15 row=%0d got px=%h want px=%h", r, px, exp_px(r, 1, 1, 0));
            end
        end
    endtask

    task automatic test_colour();
        int ticks, pos;
        logic [7:0] px;
        logic [9:0] ad;
        logic [15:0] cs[3] = '{16'h0900, 16'h0901, 16'h0900};
        bit hot[3] = '{1'b0, 1'b1, 1'b0};
        do_reset();
        set_bin(0, 16'd20);
        for (int i = 0; i < 3; i++) begin
            bus.current_sound = cs[i];
            run_pass(ticks, pos);
            probe(10, 479, px, ad);
            checks++;
            if (px !== exp_px(31, 20, 20, hot[i])) begin
                failures++;
                $display("FAIL colour sound=%h got px=%h want px=%h", cs[i], px, exp_px(31, 20, 20, hot[i]));
            end
        end
    endtask

    // Load 20 on pass 1, then feed 0; decay lands on passes k with k%4==3,
    // and the peak holds through pass 31 before decaying from pass 35.
    task automatic test_decay();
        int ticks, pos, d, p;
        logic [7:0] px;
        logic [9:0] ad;
        int rows[3];
        do_reset();
        set_bin(0, 16'd20);
        run_pass(ticks, pos);
        set_bin(0, 16'd0);
        for (int k = 2; k <= 84; k++) begin
            run_pass(ticks, pos);
            d = 20 - (k + 1) / 4;
            if (d < 0) d = 0;
            p = (k <= 34) ? 20 : 20 - ((k + 1) / 4 - 8);
            rows = '{31 - d, 32 - d, 12};
            for (int j = 0; j < 3; j++) begin
                if (rows[j] <= 31) begin
                    probe(10, rows[j] * 15 + 7, px, ad);
                    checks++;
                    if (px !== exp_px(rows[j], d, p, 0)) begin
                        failures++;
                        $display("FAIL decay pass=%0d row=%0d got px=%h want px=%h",
                                 k, rows[j], px, exp_px(rows[j], d, p, 0));
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int ticks, pos;
        logic [7:0] px;
        logic [9:0] ad;
        do_reset();
        set_bin(0, 16'd20);
        run_pass(ticks, pos);
        @(negedge vga_clk);
        bus.hc = 10'd640;
        bus.vc = 10'd480;
        ticks = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge vga_clk);
            if (bus.frame_tick) ticks++;
            if (n == 1) begin
                bus.hc = 10'd10;
                bus.vc = 10'd479;
            end
            if (n == 7) reset = 1'b1;
            if (n == 8) begin
                checks++;
                if ({bus.red, bus.green, bus.blue, bus.pixel_address, bus.frame_tick} !== 19'd0) begin
                    failures++;
                    $display("FAIL midreset_outputs got rgb=%h addr=%0d tick=%b want all 0",
                             {bus.red, bus.green, bus.blue}, bus.pixel_address, bus.frame_tick);
                end
            end
            if (n == 10) reset = 1'b0;
        end
        checks++;
        if (ticks !== 0) begin
            failures++;
            $display("FAIL midreset_tick got ticks=%0d want 0", ticks);
        end
        probe(10, 479, px, ad);
        checks++;
        if (px !== 8'h00) begin
            failures++;
            $display("FAIL midreset_cleared got px=%h want px=00", px);
        end
        run_pass(ticks, pos);
        checks++;
        if (ticks !== 1 || pos !== 17) begin
            failures++;
            $display("FAIL midreset_next_tick got ticks=%0d pos=%0d want ticks=1 pos=17", ticks, pos);
        end
        probe(10, 479, px, ad);
        checks++;
        if ({px, ad} !== {exp_px(31, 20, 20, 0), 10'd496}) begin
            failures++;
            $display("FAIL midreset_next_px got px=%h addr=%0d want px=%h addr=496", px, ad, exp_px(31, 20, 20, 0));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_colour();
        test_decay();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
